// File: rtl/cacheline_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_arbiter_if
// Purpose  : Bundles the I-cache, D-cache and memory line ports seen by the
//            cacheline arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface cacheline_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [1:0]        grant;

  // Arbiter side.
  modport master (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr,
           pmem_wdata, grant
  );

  // Caches and memory side.
  modport slave (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr,
           pmem_wdata, grant
  );
endinterface
`default_nettype wire

// File: rtl/cacheline_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_arbiter
// Purpose  : Serialises I-cache and D-cache line requests onto one memory
//            port. Macro ARB_ROUND_ROBIN_EN selects round-robin tie-break.
// Revision : 1.0  initial release
// ============================================================================
module cacheline_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  cacheline_arbiter_if.master bus
);
  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_I_BUSY  = 2'd1;
  localparam logic [1:0] c_D_BUSY  = 2'd2;
  localparam logic [1:0] c_RELEASE = 2'd3;

  localparam logic [1:0] c_GRANT_NONE = 2'b00;
  localparam logic [1:0] c_GRANT_I    = 2'b01;
  localparam logic [1:0] c_GRANT_D    = 2'b10;

  logic [1:0]        r_state;
  logic [1:0]        r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_is_write;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic              r_i_resp;
  logic              r_d_resp;

  logic w_i_req;
  logic w_d_req;
  logic w_pick_d;

  assign w_i_req = bus.i_read;
  assign w_d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // High when D won the most recent arbitration; reset value means I.
  logic r_last_grant_d;

  assign w_pick_d = w_d_req & (~w_i_req | ~r_last_grant_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant_d <= 1'b0;
    end else if (r_state == c_IDLE && (w_i_req || w_d_req)) begin
      r_last_grant_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = w_d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= c_IDLE;
      r_grant      <= c_GRANT_NONE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_is_write   <= 1'b0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_resp     <= 1'b0;
      r_d_resp     <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_pick_d) begin
            // Write wins when the D-cache raises both read and write.
            r_addr       <= bus.d_addr;
            r_wdata      <= bus.d_wdata;
            r_is_write   <= bus.d_write;
            r_pmem_write <= bus.d_write;
            r_pmem_read  <= ~bus.d_write;
            r_grant      <= c_GRANT_D;
            r_state      <= c_D_BUSY;
          end else if (w_i_req) begin
            r_addr       <= bus.i_addr;
            r_is_write   <= 1'b0;
            r_pmem_read  <= 1'b1;
            r_pmem_write <= 1'b0;
            r_grant      <= c_GRANT_I;
            r_state      <= c_I_BUSY;
          end
        end
        c_I_BUSY: begin
          if (bus.pmem_resp) begin
            r_i_rdata    <= bus.pmem_rdata;
            r_i_resp     <= 1'b1;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_state      <= c_RELEASE;
          end
        end
        c_D_BUSY: begin
          if (bus.pmem_resp) begin
            if (!r_is_write) begin
              r_d_rdata <= bus.pmem_rdata;
            end
            r_d_resp     <= 1'b1;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_state      <= c_RELEASE;
          end
        end
        default: begin
          r_i_resp <= 1'b0;
          r_d_resp <= 1'b0;
          r_grant  <= c_GRANT_NONE;
          r_state  <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.i_rdata    = r_i_rdata;
  assign bus.i_resp     = r_i_resp;
  assign bus.d_rdata    = r_d_rdata;
  assign bus.d_resp     = r_d_resp;
  assign bus.pmem_read  = r_pmem_read;
  assign bus.pmem_write = r_pmem_write;
  assign bus.pmem_addr  = r_addr;
  assign bus.pmem_wdata = r_wdata;
  assign bus.grant      = r_grant;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      if (r_state == c_IDLE) begin
        assert (!(bus.d_read && bus.d_write))
          else $warning("d_read and d_write both high; serving as a write");
      end
      assert (!(r_pmem_read && r_pmem_write))
        else $error("pmem_read and pmem_write both high");
      assert (!(r_i_resp && r_d_resp))
        else $error("i_resp and d_resp both high");
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_cacheline_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cacheline_arbiter
// Purpose  : Directed self-checking bench for cacheline_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_cacheline_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [LINE_W-1:0] exp_i_rdata;
  logic [LINE_W-1:0] exp_d_rdata;
  logic [LINE_W-1:0] line;
  logic [1:0]        exp_order [4];

  always #5 clk = ~clk;

  cacheline_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_read = 0; bus.i_addr = '0; bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.pmem_rdata = '0; bus.pmem_resp = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_order = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    exp_i_rdata = '0;
    exp_d_rdata = '0;

    // Reset state
    tick(); tick();
    check("rst_grant", bus.grant, 2'b00);
    check("rst_pmem_read", bus.pmem_read, 0);
    check("rst_pmem_write", bus.pmem_write, 0);
    check("rst_pmem_addr", bus.pmem_addr, 0);
    check("rst_i_rdata", bus.i_rdata, 0);
    check("rst_d_resp", bus.d_resp, 0);
    rst = 1;
    tick();

    // 1: single I-cache fill, pmem_resp in cycle 4
    bus.i_read = 1; bus.i_addr = 32'h0000_0060;
    tick();
    check("t1_c1_read", bus.pmem_read, 1);
    check("t1_c1_addr", bus.pmem_addr, 32'h60);
    check("t1_c1_grant", bus.grant, 2'b01);
    tick(); tick(); tick();
    check("t1_c4_read", bus.pmem_read, 1);
    bus.pmem_resp = 1; bus.pmem_rdata = {32{8'hA5}};
    tick();
    bus.pmem_resp = 0;
    exp_i_rdata = {32{8'hA5}};
    check("t1_c5_iresp", bus.i_resp, 1);
    check("t1_c5_rdata", bus.i_rdata, exp_i_rdata);
    check("t1_c5_read", bus.pmem_read, 0);
    check("t1_c5_grant", bus.grant, 2'b01);
    bus.i_read = 0;
    tick();
    check("t1_c6_iresp", bus.i_resp, 0);
    check("t1_c6_grant", bus.grant, 2'b00);

    // 2: simultaneous I and D reads
    bus.i_read = 1; bus.i_addr = 32'hC0;
    bus.d_read = 1; bus.d_addr = 32'h80;
    tick();
    check("t2_d_grant", bus.grant, 2'b10);
    check("t2_d_addr", bus.pmem_addr, 32'h80);
    bus.pmem_resp = 1; bus.pmem_rdata = {32{8'hD1}};
    tick();
    bus.pmem_resp = 0;
    exp_d_rdata = {32{8'hD1}};
    check("t2_d_resp", bus.d_resp, 1);
    check("t2_i_noresp", bus.i_resp, 0);
    check("t2_d_rdata", bus.d_rdata, exp_d_rdata);
    check("t2_rel_read", bus.pmem_read, 0);
    bus.d_read = 0;
    tick();
    check("t2_idle_read", bus.pmem_read, 0);
    check("t2_idle_grant", bus.grant, 2'b00);
    tick();
    check("t2_i_grant", bus.grant, 2'b01);
    check("t2_i_read", bus.pmem_read, 1);
    check("t2_i_addr", bus.pmem_addr, 32'hC0);
    bus.pmem_resp = 1; bus.pmem_rdata = {32{8'h1E}};
    tick();
    bus.pmem_resp = 0;
    exp_i_rdata = {32{8'h1E}};
    check("t2_i_resp", bus.i_resp, 1);
    check("t2_i_rdata", bus.i_rdata, exp_i_rdata);
    check("t2_d_rdata_hold", bus.d_rdata, exp_d_rdata);
    bus.i_read = 0;
    tick();

    // 3: both ports request continuously
    bus.i_read = 1; bus.d_read = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t3_grant%0d", k), bus.grant, exp_order[k]);
      line = {32{8'h30 + 8'(k)}};
      bus.pmem_resp = 1; bus.pmem_rdata = line;
      tick();
      bus.pmem_resp = 0;
      if (exp_order[k] == 2'b10) begin
        exp_d_rdata = line;
        check($sformatf("t3_dresp%0d", k), bus.d_resp, 1);
      end else begin
        exp_i_rdata = line;
        check($sformatf("t3_iresp%0d", k), bus.i_resp, 1);
      end
      check($sformatf("t3_irdata%0d", k), bus.i_rdata, exp_i_rdata);
      check($sformatf("t3_drdata%0d", k), bus.d_rdata, exp_d_rdata);
      tick();
      check($sformatf("t3_idle%0d", k), bus.grant, 2'b00);
    end
    bus.i_read = 0; bus.d_read = 0;
    tick();
    check("t3_end_grant", bus.grant, 2'b00);

    // 4: D writeback, request dropped mid-service
    bus.d_write = 1; bus.d_addr = 32'h40; bus.d_wdata = {16{16'h1234}};
    tick();
    check("t4_write", bus.pmem_write, 1);
    check("t4_read", bus.pmem_read, 0);
    check("t4_addr", bus.pmem_addr, 32'h40);
    check("t4_wdata", bus.pmem_wdata, {16{16'h1234}});
    check("t4_grant", bus.grant, 2'b10);
    bus.d_write = 0; bus.d_wdata = '0;
    tick();
    check("t4_write_hold", bus.pmem_write, 1);
    check("t4_wdata_hold", bus.pmem_wdata, {16{16'h1234}});
    bus.pmem_resp = 1; bus.pmem_rdata = {32{8'hFF}};
    tick();
    bus.pmem_resp = 0;
    check("t4_dresp", bus.d_resp, 1);
    check("t4_rdata_kept", bus.d_rdata, exp_d_rdata);
    check("t4_write_drop", bus.pmem_write, 0);
    tick();
    check("t4_dresp_off", bus.d_resp, 0);

    // 5: read and write together -> write; then stray pmem_resp in IDLE
    bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'h100; bus.d_wdata = {8{32'hCAFE_F00D}};
    tick();
    check("t5_write", bus.pmem_write, 1);
    check("t5_noread", bus.pmem_read, 0);
    check("t5_wdata", bus.pmem_wdata, {8{32'hCAFE_F00D}});
    bus.d_read = 0; bus.d_write = 0;
    bus.pmem_resp = 1; bus.pmem_rdata = {32{8'h77}};
    tick();
    bus.pmem_resp = 0;
    check("t5_dresp", bus.d_resp, 1);
    check("t5_rdata_kept", bus.d_rdata, exp_d_rdata);
    tick();
    bus.pmem_resp = 1; bus.pmem_rdata = {32{8'h99}};
    tick();
    bus.pmem_resp = 0;
    check("t5_stray_iresp", bus.i_resp, 0);
    check("t5_stray_dresp", bus.d_resp, 0);
    check("t5_stray_grant", bus.grant, 2'b00);
    check("t5_stray_irdata", bus.i_rdata, exp_i_rdata);
    tick();
    check("t5_still_idle", bus.pmem_read, 0);

    // 6: async reset during D_BUSY, then a normal I fill
    bus.d_read = 1; bus.d_addr = 32'h200;
    tick();
    check("t6_busy_read", bus.pmem_read, 1);
    #3 rst = 0;
    #1;
    check("t6_rst_read", bus.pmem_read, 0);
    check("t6_rst_grant", bus.grant, 2'b00);
    check("t6_rst_addr", bus.pmem_addr, 0);
    bus.d_read = 0;
    tick();
    rst = 1;
    exp_i_rdata = '0; exp_d_rdata = '0;
    check("t6_rst_irdata", bus.i_rdata, exp_i_rdata);
    check("t6_rst_drdata", bus.d_rdata, exp_d_rdata);
    tick();
    bus.i_read = 1; bus.i_addr = 32'h300;
    tick();
    check("t6_i_read", bus.pmem_read, 1);
    check("t6_i_addr", bus.pmem_addr, 32'h300);
    check("t6_i_grant", bus.grant, 2'b01);
    bus.pmem_resp = 1; bus.pmem_rdata = {32{8'hC3}};
    tick();
    bus.pmem_resp = 0;
    bus.i_read = 0;
    check("t6_i_resp", bus.i_resp, 1);
    check("t6_i_rdata", bus.i_rdata, {32{8'hC3}});
    tick();
    check("t6_end_grant", bus.grant, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
